// File: rtl/led_sequencer_if.sv
// Bus bundle for led_sequencer: CPU-facing register port (s_*) and PIO-facing write port (m_*).
// The slave modport is the sequencer's view; the master modport is the CPU/PIO side.
interface led_sequencer_if;
    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    // A PIO write completes on the cycle where m_chipselect & ~m_write_n & ~m_waitrequest;
    // m_address/m_writedata/strobes are held constant from issue until that cycle.
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    modport slave (
        input  s_address, s_chipselect, s_write_n, s_writedata,
        output s_readdata,
        output m_address, m_chipselect, m_write_n, m_writedata,
        input  m_waitrequest
    );

    modport master (
        output s_address, s_chipselect, s_write_n, s_writedata,
        input  s_readdata,
        input  m_address, m_chipselect, m_write_n, m_writedata,
        output m_waitrequest
    );
endinterface

// File: rtl/led_sequencer.sv
// Replays a CPU-loaded LED pattern table onto PIO register 0, one Avalon write per step,
// with a programmable number of clocks between steps.
module led_sequencer #(
    parameter int DEPTH    = 8,
    parameter int PERIOD_W = 24,
    parameter int LED_W    = 7
) (
    input  logic           clk,
    input  logic           reset,
    led_sequencer_if.slave bus,
    output logic           busy,
    output logic [1:0]     state_dbg
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]          state;
    logic                run, loop_en, done;
    logic [IDX_W-1:0]    last, step, next_step, wr_idx;
    logic [PERIOD_W-1:0] period, cnt, load_val;
    logic [LED_W-1:0]    pattern [DEPTH];
    logic                wr_en, wr_ctrl, wr_period, wr_table, wr_status;
    logic                seq_end;
    logic                unused_wd;

    assign wr_en     = bus.s_chipselect & ~bus.s_write_n;
    assign wr_ctrl   = wr_en && (bus.s_address == 2'd0);
    assign wr_period = wr_en && (bus.s_address == 2'd1);
    assign wr_table  = wr_en && (bus.s_address == 2'd2);
    assign wr_status = wr_en && (bus.s_address == 2'd3);
    assign wr_idx    = bus.s_writedata[16 +: IDX_W];
    assign unused_wd = ^bus.s_writedata;

    // A period of 0 behaves like 1: the counter is loaded with max(PERIOD,1)-1.
    assign load_val  = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign next_step = (step == last) ? '0 : step + IDX_W'(1);
    assign seq_end   = (state == HOLD) && run && (cnt == '0) && (step == last) && !loop_en;

    assign busy          = (state != IDLE);
    assign state_dbg     = state;
    assign bus.m_address = 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pattern[i] <= '0;
        end else if (wr_table) begin
            pattern[wr_idx] <= bus.s_writedata[LED_W-1:0];
        end
    end

    // Control/status registers; hardware setting done beats a same-cycle CPU clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run     <= 1'b0;
            loop_en <= 1'b0;
            last    <= '0;
            period  <= PERIOD_W'(1);
            done    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                run     <= bus.s_writedata[0];
                loop_en <= bus.s_writedata[1];
                last    <= bus.s_writedata[8 +: IDX_W];
            end else if (seq_end) begin
                run <= 1'b0;
            end
            if (wr_period) period <= bus.s_writedata[PERIOD_W-1:0];
            if (state == IDLE && run) done <= 1'b0;
            else if (seq_end)         done <= 1'b1;
            else if (wr_status)       done <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            step             <= '0;
            cnt              <= '0;
            bus.m_chipselect <= 1'b0;
            bus.m_write_n    <= 1'b1;
            bus.m_writedata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state            <= WRITE;
                        step             <= '0;
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_writedata  <= {{(32-LED_W){1'b0}}, pattern[0]};
                    end
                end
                WRITE: begin
                    // An issued transfer always runs to completion, even if run was cleared.
                    if (!bus.m_waitrequest) begin
                        bus.m_chipselect <= 1'b0;
                        bus.m_write_n    <= 1'b1;
                        cnt              <= load_val;
                        state            <= run ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - PERIOD_W'(1);
                    end else if ((step == last) && !loop_en) begin
                        state <= IDLE;
                    end else begin
                        step             <= next_step;
                        state            <= WRITE;
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_writedata  <= {{(32-LED_W){1'b0}}, pattern[next_step]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.s_readdata = '0;
        case (bus.s_address)
            2'd0: begin
                bus.s_readdata[0]          = run;
                bus.s_readdata[1]          = loop_en;
                bus.s_readdata[8 +: IDX_W] = last;
            end
            2'd1: bus.s_readdata[PERIOD_W-1:0] = period;
            2'd3: begin
                bus.s_readdata[0]          = done;
                bus.s_readdata[1]          = busy;
                bus.s_readdata[8 +: IDX_W] = step;
            end
            default: bus.s_readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: CPU register writes drive the stimulus, a PIO-side
// monitor pops the expected pattern queue on every completed master write.
module tb_led_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [1:0] state_dbg;

    led_sequencer_if bus ();

    led_sequencer #(.DEPTH(8), .PERIOD_W(24), .LED_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_count = 0;
    int wr_cyc[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // PIO side: a write completes at the edge following a negedge with strobes up and no stall.
    always @(negedge clk) begin
        if (!reset && bus.m_chipselect && !bus.m_write_n && !bus.m_waitrequest) begin
            logic [31:0] exp;
            wr_count++;
            wr_cyc.push_back(cyc);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("pio_data", bus.m_writedata, exp);
            check("pio_addr", bus.m_address, 2'b00);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.s_address    = a;
        bus.s_writedata  = d;
        bus.s_chipselect = 1'b1;
        bus.s_write_n    = 1'b0;
        @(posedge clk); #1;
        bus.s_chipselect = 1'b0;
        bus.s_write_n    = 1'b1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.s_address = a;
        @(negedge clk);
        d = bus.s_readdata;
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (wr_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("write_count", wr_count, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_cs(input int budget);
        int n = 0;
        while (!bus.m_chipselect && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("cs_timeout", bus.m_chipselect, 1'b1);
    endtask

    initial begin
        logic [31:0] rd;
        int base;

        bus.s_address     = 2'd0;
        bus.s_chipselect  = 1'b0;
        bus.s_write_n     = 1'b1;
        bus.s_writedata   = '0;
        bus.m_waitrequest = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_write_n", bus.m_write_n, 1'b1);
        check("rst_cs", bus.m_chipselect, 1'b0);
        check("rst_wdata", bus.m_writedata, 32'h0);
        check("rst_busy", busy, 1'b0);
        cpu_read(2'd0, rd); check("rst_ctrl", rd, 32'h0);
        cpu_read(2'd1, rd); check("rst_period", rd, 32'h1);
        cpu_read(2'd2, rd); check("rst_table", rd, 32'h0);
        cpu_read(2'd3, rd); check("rst_status", rd, 32'h0);

        // One-shot sequence, PERIOD=5 -> writes 6 clocks apart
        cpu_write(2'd2, 32'h0000_0001);
        cpu_write(2'd2, 32'h0001_0002);
        cpu_write(2'd2, 32'h0002_0004);
        cpu_write(2'd1, 32'd5);
        base = wr_count;
        exp_q.push_back(32'h01); exp_q.push_back(32'h02); exp_q.push_back(32'h04);
        cpu_write(2'd0, 32'h0000_0201);
        wait_writes(base + 3, 200);
        check("spacing_01", wr_cyc[base+1] - wr_cyc[base], 6);
        check("spacing_12", wr_cyc[base+2] - wr_cyc[base+1], 6);
        wait_idle(100);
        cpu_read(2'd3, rd); check("oneshot_status", rd, 32'h0000_0201);
        cpu_read(2'd0, rd); check("oneshot_ctrl", rd, 32'h0000_0200);
        cpu_read(2'd1, rd); check("period_rd", rd, 32'd5);

        // Looping sequence, run cleared in HOLD after the 7th write
        base = wr_count;
        for (int i = 0; i < 7; i++) begin
            logic [31:0] pat [3];
            pat[0] = 32'h01; pat[1] = 32'h02; pat[2] = 32'h04;
            exp_q.push_back(pat[i % 3]);
        end
        cpu_write(2'd0, 32'h0000_0203);
        wait_writes(base + 7, 400);
        cpu_write(2'd0, 32'h0000_0202);
        repeat (30) @(negedge clk);
        check("loop_no_extra", wr_count, base + 7);
        check("loop_busy", busy, 1'b0);
        cpu_read(2'd3, rd); check("loop_status", rd, 32'h0);

        // Wait-state stretch: 3 stalled cycles, outputs stable, HOLD timed from completion
        cpu_write(2'd2, 32'h0000_0011);
        cpu_write(2'd1, 32'd2);
        bus.m_waitrequest = 1'b1;
        base = wr_count;
        exp_q.push_back(32'h11);
        cpu_write(2'd0, 32'h0000_0001);
        wait_cs(20);
        for (int i = 0; i < 4; i++) begin
            check("wait_stable", {bus.m_chipselect, bus.m_write_n, bus.m_address, bus.m_writedata},
                  {1'b1, 1'b0, 2'b00, 32'h11});
            if (i < 3) begin
                @(posedge clk); #1;
                if (i == 2) bus.m_waitrequest = 1'b0;
                @(negedge clk);
            end
        end
        @(negedge clk); check("hold_1", state_dbg, 2'd2);
        @(negedge clk); check("hold_2", state_dbg, 2'd2);
        @(negedge clk); check("hold_done", busy, 1'b0);
        check("wait_one_write", wr_count, base + 1);

        // run cleared while the first write is stalled: it still completes, then IDLE
        cpu_write(2'd2, 32'h0000_0001);
        cpu_write(2'd1, 32'd3);
        bus.m_waitrequest = 1'b1;
        base = wr_count;
        exp_q.push_back(32'h01);
        cpu_write(2'd0, 32'h0000_0203);
        wait_cs(20);
        bus.s_address    = 2'd0;
        bus.s_writedata  = 32'h0000_0202;
        bus.s_chipselect = 1'b1;
        bus.s_write_n    = 1'b0;
        @(posedge clk); #1;
        bus.s_chipselect = 1'b0;
        bus.s_write_n    = 1'b1;
        @(posedge clk); #1;
        bus.m_waitrequest = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_idle", state_dbg, 2'd0);
        check("abort_cs", bus.m_chipselect, 1'b0);
        repeat (20) @(negedge clk);
        check("abort_one_write", wr_count, base + 1);
        cpu_read(2'd3, rd); check("abort_status", rd, 32'h0);

        // Async reset in the middle of a stalled transfer
        cpu_write(2'd2, 32'h0000_0005);
        bus.m_waitrequest = 1'b1;
        cpu_write(2'd0, 32'h0000_0001);
        wait_cs(20);
        base = wr_count;
        reset = 1'b1;
        #1;
        check("areset_cs", bus.m_chipselect, 1'b0);
        check("areset_write_n", bus.m_write_n, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bus.m_waitrequest = 1'b0;
        repeat (20) @(negedge clk);
        check("areset_no_write", wr_count, base);
        cpu_read(2'd0, rd); check("areset_ctrl", rd, 32'h0);
        cpu_read(2'd1, rd); check("areset_period", rd, 32'h1);
        cpu_read(2'd3, rd); check("areset_status", rd, 32'h0);
        // Table entry 0 was cleared, so a restart must write zero
        exp_q.push_back(32'h00);
        cpu_write(2'd0, 32'h0000_0001);
        wait_writes(base + 1, 50);
        wait_idle(50);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
